// File: rtl/arm_cu_pkg.sv
// Shared definitions for the ARM-subset multi-cycle control unit.
// The state encoding is visible on the State output and must stay fixed.
package arm_cu_pkg;

    typedef enum logic [3:0] {
        StReset     = 4'd0,
        StFetchAddr = 4'd1,
        StFetchReq  = 4'd2,
        StFetchWait = 4'd3,
        StDecode    = 4'd4,
        StExecDp    = 4'd5,
        StBranch    = 4'd6,
        StMemAddr   = 4'd7,
        StMemReq    = 4'd8,
        StMemWait   = 4'd9,
        StLoadWb    = 4'd10,
        StBaseWb    = 4'd11,
        StAbort     = 4'd12
    } state_e;

    // IR field bit positions
    localparam int unsigned CondHi   = 31;
    localparam int unsigned CondLo   = 28;
    localparam int unsigned ClassHi  = 27;
    localparam int unsigned ClassLo  = 25;
    localparam int unsigned BitP     = 24;
    localparam int unsigned BitLink  = 24;
    localparam int unsigned BitU     = 23;
    localparam int unsigned BitB     = 22;
    localparam int unsigned BitW     = 21;
    localparam int unsigned BitL     = 20;
    localparam int unsigned BitS     = 20;
    localparam int unsigned OpcodeHi = 24;
    localparam int unsigned OpcodeLo = 21;

    localparam logic [3:0] OpTst = 4'b1000;
    localparam logic [3:0] OpTeq = 4'b1001;
    localparam logic [3:0] OpCmp = 4'b1010;
    localparam logic [3:0] OpCmn = 4'b1011;

    // Compare/test opcodes only update flags and never write Rd.
    function automatic logic is_test_op(input logic [3:0] op);
        return (op == OpTst) || (op == OpTeq) || (op == OpCmp) || (op == OpCmn);
    endfunction

endpackage

// File: rtl/arm_cu_moc_timer.sv
// Wait-state counter for the MOV/MOC handshake; expired_o flags the last allowed
// wait cycle. A Limit of 0 disables expiry.
module arm_cu_moc_timer #(
    parameter int unsigned Width = 5,
    parameter int unsigned Limit = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [Width-1:0] LastCnt = (Limit == 0) ? '0 : Width'(Limit - 1);

    logic [Width-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Saturates so a disabled timer never wraps back into a false match.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired_o = (Limit != 0) && (cnt_q == LastCnt);

endmodule

// File: rtl/arm_mc_control_unit.sv
// Multi-cycle control unit: fetch, condition check, decode and execute for DP,
// load/store and branch, with MOC timeout abort. Optional LDRB/STRB: ARM_CU_BYTE_EN.
module arm_mc_control_unit
    import arm_cu_pkg::*;
#(
    parameter int unsigned MOC_TIMEOUT = 16,
    parameter int unsigned TMR_W       = 5
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [31:0] IR,
    input  logic        Cond,
    input  logic        MOC,
    output logic [3:0]  State,
    output logic        MOV,
    output logic        RW,
    output logic        MAR_Ld,
    output logic        MDR_Ld,
    output logic        IR_Ld,
    output logic        PC_Ld,
    output logic        RF_Ld,
    output logic        Base_Ld,
    output logic        Flags_Ld,
    output logic        Abort,
    output logic        Undef
`ifdef ARM_CU_BYTE_EN
    ,
    output logic        ByteEn
`endif
);

    state_e state_q, state_d;

    logic is_dp, is_br, is_mem, is_load, needs_wb, is_test;
    logic tmr_clr, tmr_en, tmr_expired;
    logic unused_ir_bits;

    assign is_dp = (IR[ClassHi -: 2] == 2'b00);
    assign is_br = (IR[ClassHi:ClassLo] == 3'b101);
`ifdef ARM_CU_BYTE_EN
    assign is_mem = (IR[ClassHi -: 2] == 2'b01);
`else
    assign is_mem = (IR[ClassHi -: 2] == 2'b01) && !IR[BitB];
`endif
    assign is_load  = IR[BitL];
    assign needs_wb = !IR[BitP] || IR[BitW];
    assign is_test  = is_test_op(IR[OpcodeHi:OpcodeLo]);

    // U selects add/subtract inside the datapath; condition bits go to the tester.
    assign unused_ir_bits = ^{IR[CondHi:CondLo], IR[BitU], IR[19:0]};

    // Counter is zeroed in each REQ state, so it reads 0 in the first wait cycle.
    assign tmr_clr = (state_q == StFetchReq) || (state_q == StMemReq);
    assign tmr_en  = ((state_q == StFetchWait) || (state_q == StMemWait)) && !MOC;

    arm_cu_moc_timer #(
        .Width (TMR_W),
        .Limit (MOC_TIMEOUT)
    ) u_moc_timer (
        .clk_i     (Clk),
        .rst_ni    (Clr),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset:     state_d = StFetchAddr;
            StFetchAddr: state_d = StFetchReq;
            StFetchReq:  state_d = StFetchWait;
            StFetchWait: begin
                if (MOC) begin
                    state_d = StDecode;
                end else if (tmr_expired) begin
                    state_d = StAbort;
                end
            end
            StDecode: begin
                if (!Cond) begin
                    state_d = StFetchAddr;
                end else if (is_dp) begin
                    state_d = StExecDp;
                end else if (is_br) begin
                    state_d = StBranch;
                end else if (is_mem) begin
                    state_d = StMemAddr;
                end else begin
                    state_d = StFetchAddr;
                end
            end
            StExecDp:  state_d = StFetchAddr;
            StBranch:  state_d = StFetchAddr;
            StMemAddr: state_d = StMemReq;
            StMemReq:  state_d = StMemWait;
            StMemWait: begin
                if (MOC) begin
                    if (is_load) begin
                        state_d = StLoadWb;
                    end else begin
                        state_d = needs_wb ? StBaseWb : StFetchAddr;
                    end
                end else if (tmr_expired) begin
                    state_d = StAbort;
                end
            end
            StLoadWb: state_d = needs_wb ? StBaseWb : StFetchAddr;
            StBaseWb: state_d = StFetchAddr;
            StAbort:  state_d = StFetchAddr;
            default:  state_d = StReset;
        endcase
    end

    always_comb begin
        MOV      = 1'b0;
        RW       = 1'b0;
        MAR_Ld   = 1'b0;
        MDR_Ld   = 1'b0;
        IR_Ld    = 1'b0;
        PC_Ld    = 1'b0;
        RF_Ld    = 1'b0;
        Base_Ld  = 1'b0;
        Flags_Ld = 1'b0;
        Abort    = 1'b0;
        Undef    = 1'b0;
        case (state_q)
            StFetchAddr: MAR_Ld = 1'b1;
            StFetchReq: begin
                MOV   = 1'b1;
                RW    = 1'b1;
                PC_Ld = 1'b1;
            end
            StFetchWait: begin
                MOV   = 1'b1;
                RW    = 1'b1;
                IR_Ld = MOC;
            end
            StDecode: Undef = Cond && !(is_dp || is_br || is_mem);
            StExecDp: begin
                RF_Ld    = !is_test;
                Flags_Ld = IR[BitS] || is_test;
            end
            StBranch: begin
                PC_Ld = 1'b1;
                RF_Ld = IR[BitLink];
            end
            StMemAddr: begin
                MAR_Ld = 1'b1;
                MDR_Ld = !is_load;
            end
            StMemReq: begin
                MOV = 1'b1;
                RW  = is_load;
            end
            StMemWait: begin
                MOV    = 1'b1;
                RW     = is_load;
                MDR_Ld = MOC && is_load;
            end
            StLoadWb: RF_Ld   = 1'b1;
            StBaseWb: Base_Ld = 1'b1;
            StAbort:  Abort   = 1'b1;
            default: ;
        endcase
    end

`ifdef ARM_CU_BYTE_EN
    always_comb begin
        ByteEn = 1'b0;
        if ((state_q == StMemAddr) || (state_q == StMemReq) || (state_q == StMemWait)) begin
            ByteEn = IR[BitB];
        end
    end
`endif

    assign State = state_q;

endmodule

// File: tb/tb_arm_mc_control_unit.sv
// Self-checking bench for arm_mc_control_unit: table vectors with hand-derived state
// traces, hand sequences for reset/timeout, and random instructions vs a trace model.
module tb_arm_mc_control_unit;

    localparam int unsigned To = 16;

    localparam logic [10:0] OMov  = 11'h400;
    localparam logic [10:0] ORw   = 11'h200;
    localparam logic [10:0] OMar  = 11'h100;
    localparam logic [10:0] OMdr  = 11'h080;
    localparam logic [10:0] OIr   = 11'h040;
    localparam logic [10:0] OPc   = 11'h020;
    localparam logic [10:0] ORf   = 11'h010;
    localparam logic [10:0] OBase = 11'h008;
    localparam logic [10:0] OFlg  = 11'h004;
    localparam logic [10:0] OAbt  = 11'h002;
    localparam logic [10:0] OUnd  = 11'h001;

    logic        Clk = 1'b0;
    logic        Clr;
    logic [31:0] IR;
    logic        Cond;
    logic        MOC;
    logic [3:0]  State;
    logic MOV, RW, MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, RF_Ld, Base_Ld, Flags_Ld, Abort, Undef;
`ifdef ARM_CU_BYTE_EN
    logic ByteEn;
`endif

    arm_mc_control_unit #(
        .MOC_TIMEOUT (To),
        .TMR_W       (5)
    ) dut (
        .Clk      (Clk),
        .Clr      (Clr),
        .IR       (IR),
        .Cond     (Cond),
        .MOC      (MOC),
        .State    (State),
        .MOV      (MOV),
        .RW       (RW),
        .MAR_Ld   (MAR_Ld),
        .MDR_Ld   (MDR_Ld),
        .IR_Ld    (IR_Ld),
        .PC_Ld    (PC_Ld),
        .RF_Ld    (RF_Ld),
        .Base_Ld  (Base_Ld),
        .Flags_Ld (Flags_Ld),
        .Abort    (Abort),
        .Undef    (Undef)
`ifdef ARM_CU_BYTE_EN
        ,
        .ByteEn   (ByteEn)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] cur_ir;

    logic [3:0]  exp_st[$];
    logic [10:0] exp_out[$];
    logic        exp_moc[$];

    typedef struct {
        logic [31:0] ir;
        bit          cond;
        int          fd;
        int          md;
        logic [63:0] states;
        int          n;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [10:0] outs();
        return {MOV, RW, MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, RF_Ld, Base_Ld, Flags_Ld, Abort, Undef};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s ir=%h t=%0t: got %h, expected %h", name, cur_ir, $time, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [10:0] o, input logic moc);
        exp_st.push_back(st);
        exp_out.push_back(o);
        exp_moc.push_back(moc);
    endtask

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    // One wait phase: MOC comes after d idle cycles, unless the timeout fires first.
    task automatic wait_phase(input logic [3:0] st, input int d, input logic [10:0] base,
                              input logic [10:0] done, output bit ok);
        for (int i = 0; ; i++) begin
            if (i == d) begin
                push(st, base | done, 1'b1);
                ok = 1'b1;
                return;
            end
            if ((To > 0) && (i == int'(To) - 1)) begin
                push(st, base, 1'b0);
                push(4'd12, OAbt, rnd());
                ok = 1'b0;
                return;
            end
            push(st, base, 1'b0);
        end
    endtask

    // Expected per-cycle trace of one instruction, starting in the fetch-address state.
    task automatic build(input logic [31:0] ir, input bit cond, input int fd, input int md);
        bit ok, dp, br, mem, load, wb, test;
        exp_st.delete();
        exp_out.delete();
        exp_moc.delete();
        dp   = (ir[27:26] == 2'b00);
        br   = (ir[27:25] == 3'b101);
`ifdef ARM_CU_BYTE_EN
        mem  = (ir[27:26] == 2'b01);
`else
        mem  = (ir[27:26] == 2'b01) && !ir[22];
`endif
        load = ir[20];
        wb   = !ir[24] || ir[21];
        test = (ir[24:23] == 2'b10);
        push(4'd1, OMar, rnd());
        push(4'd2, OMov | ORw | OPc, rnd());
        wait_phase(4'd3, fd, OMov | ORw, OIr, ok);
        if (!ok) return;
        if (!cond) begin
            push(4'd4, '0, rnd());
            return;
        end
        if (!(dp || br || mem)) begin
            push(4'd4, OUnd, rnd());
            return;
        end
        push(4'd4, '0, rnd());
        if (dp) begin
            push(4'd5, (test ? 11'h0 : ORf) | ((ir[20] || test) ? OFlg : 11'h0), rnd());
        end else if (br) begin
            push(4'd6, OPc | (ir[24] ? ORf : 11'h0), rnd());
        end else begin
            push(4'd7, OMar | (load ? 11'h0 : OMdr), rnd());
            push(4'd8, OMov | (load ? ORw : 11'h0), rnd());
            wait_phase(4'd9, md, OMov | (load ? ORw : 11'h0), load ? OMdr : 11'h0, ok);
            if (!ok) return;
            if (load) push(4'd10, ORf, rnd());
            if (wb) push(4'd11, OBase, rnd());
        end
    endtask

    task automatic exec(input logic [31:0] ir, input bit cond, input int fd, input int md,
                        input logic [63:0] tbl, input int tbl_n,
                        output int n_abort, output int n_rf, output int n_base,
                        output int n_wait9);
        logic [3:0] nib;
        n_abort = 0;
        n_rf    = 0;
        n_base  = 0;
        n_wait9 = 0;
        cur_ir  = ir;
        build(ir, cond, fd, md);
        for (int k = 0; k < exp_st.size(); k++) begin
            @(negedge Clk);
            IR   = ir;
            MOC  = exp_moc[k];
            Cond = (exp_st[k] == 4'd4) ? logic'(cond) : rnd();
            #1;
            check("state", 32'(State), 32'(exp_st[k]));
            check("strobes", 32'(outs()), 32'(exp_out[k]));
`ifdef ARM_CU_BYTE_EN
            check("byte_en", 32'(ByteEn),
                  32'(ir[22] && (exp_st[k] >= 4'd7) && (exp_st[k] <= 4'd9)));
`endif
            if (k < tbl_n) begin
                nib = 4'(tbl >> (4 * (tbl_n - 1 - k)));
                check("table_state", 32'(State), 32'(nib));
            end
            n_abort += int'(Abort);
            n_rf    += int'(RF_Ld);
            n_base  += int'(Base_Ld);
            n_wait9 += int'(State == 4'd9);
        end
    endtask

    initial begin
        int na, nr, nb, nw, sel, fd, md;
        logic [31:0] ir;
        bit cond;

        vecs[0] = '{32'hE2821005, 1'b1, 2, 2, 64'h1233345, 7};       // ADD R1,R2,#5
        vecs[1] = '{32'hE3510000, 1'b1, 2, 2, 64'h1233345, 7};       // CMP R1,#0
        vecs[2] = '{32'hE3510000, 1'b0, 2, 2, 64'h123334, 6};        // CMP, cond fails
        vecs[3] = '{32'hE5910004, 1'b1, 2, 2, 64'h12333478999A, 12}; // LDR pre, no W
        vecs[4] = '{32'hE4910004, 1'b1, 2, 2, 64'h12333478999AB, 13};// LDR post
        vecs[5] = '{32'hE5A10004, 1'b1, 2, 2, 64'h12333478999B, 12}; // STR pre, W=1
        vecs[6] = '{32'hEB000002, 1'b1, 2, 2, 64'h1233346, 7};       // BL
        vecs[7] = '{32'hE8900003, 1'b1, 2, 2, 64'h123334, 6};        // LDM -> Undef
        vecs[8] = '{32'hE2821005, 1'b1, 0, 0, 64'h12345, 5};         // immediate MOC
        vecs[9] = '{32'hE5810004, 1'b1, 1, 0, 64'h12334789, 8};      // STR pre, no W

        cur_ir = '0;
        Clr  = 1'b0;
        IR   = '0;
        MOC  = 1'b1;
        Cond = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        check("reset_state", 32'(State), 32'd0);
        check("reset_strobes", 32'(outs()), 32'd0);
        @(negedge Clk);
        Clr = 1'b1;
        #1;
        check("post_reset_state", 32'(State), 32'd0);

        for (int v = 0; v < 10; v++) begin
            exec(vecs[v].ir, vecs[v].cond, vecs[v].fd, vecs[v].md, vecs[v].states, vecs[v].n,
                 na, nr, nb, nw);
        end

        // Memory timeout: 16 silent wait cycles abort; MOC in the 16th completes.
        exec(32'hE5910004, 1'b1, 2, 16, '0, 0, na, nr, nb, nw);
        check("to_abort_cnt", 32'(na), 32'd1);
        check("to_abort_rf", 32'(nr), 32'd0);
        check("to_abort_base", 32'(nb), 32'd0);
        check("to_abort_waits", 32'(nw), 32'd16);
        exec(32'hE5910004, 1'b1, 2, 15, '0, 0, na, nr, nb, nw);
        check("to_edge_abort", 32'(na), 32'd0);
        check("to_edge_rf", 32'(nr), 32'd1);
        check("to_edge_waits", 32'(nw), 32'd16);
        exec(32'hE2821005, 1'b1, 16, 0, '0, 0, na, nr, nb, nw);
        check("fetch_to_abort", 32'(na), 32'd1);

        // Asynchronous reset in the middle of a fetch handshake.
        cur_ir = 32'hEB000002;
        IR  = cur_ir;
        MOC = 1'b0;
        @(negedge Clk);
        #1;
        check("mid_rst_s1", 32'(State), 32'd1);
        repeat (2) @(negedge Clk);
        #1;
        check("mid_rst_s3", 32'(State), 32'd3);
        check("mid_rst_mov_before", 32'(MOV), 32'd1);
        #1 Clr = 1'b0;
        #1;
        check("mid_rst_state", 32'(State), 32'd0);
        check("mid_rst_mov", 32'(MOV), 32'd0);
        @(negedge Clk);
        Clr = 1'b1;
        #1;
        check("mid_rst_hold", 32'(State), 32'd0);

        for (int r = 0; r < 60; r++) begin
            ir  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel <= 2) begin
                ir[27:26] = 2'b00;
                if ($urandom_range(0, 2) == 0) ir[24:23] = 2'b10;
            end else if (sel == 3) begin
                ir[27:25] = 3'b101;
            end else if (sel <= 7) begin
                ir[27:26] = 2'b01;
                ir[22]    = ($urandom_range(0, 3) == 0);
            end
            cond = ($urandom_range(0, 4) != 0);
            fd = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 4);
            md = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 4);
            exec(ir, cond, fd, md, '0, 0, na, nr, nb, nw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
